// File: rtl/ps2_pkg.sv
// Shared constants, event layout and decoder states for the PS/2 keyboard event queue.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ERR_00 = 8'h00;
   localparam logic [7:0] PS2_ERR_FF = 8'hFF;
   localparam logic [7:0] PS2_ERR_FC = 8'hFC;
   localparam logic [7:0] PS2_ERR_FD = 8'hFD;

   typedef struct packed {
      logic       rel;
      logic       ext;
      logic [5:0] pad;
      logic [7:0] code;
   } kbd_event_t;

   typedef enum logic [2:0] {IDLE, EXT, REL, EXT_REL, SKIP} dec_state_t;

   function automatic logic is_err_byte(input logic [7:0] b);
      return (b == PS2_ERR_00) || (b == PS2_ERR_FF) || (b == PS2_ERR_FC) || (b == PS2_ERR_FD);
   endfunction

   // Controller replies that never become key events.
   function automatic logic is_filtered(input logic [7:0] b);
      return (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_BAT) || is_err_byte(b);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count and simultaneous push/pop.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic                       clk50,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_pop_s;
   logic             do_push_s;

   assign valid = (count_r != CW'(0));
   assign full  = (count_r == CW'(DEPTH));
   assign count = count_r;
   assign head  = valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      do_pop_s  = pop && valid;
      do_push_s = push && (!full || do_pop_s);
   end

   // Storage write port.
   always_ff @(posedge clk50) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk50) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/ps2_event_queue.sv
// PS/2 set-2 byte decoder feeding a show-ahead event FIFO with IRQ and sticky status.
module ps2_event_queue
   import ps2_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int PAUSE_SKIP = 7
) (
   input  logic                   clk50,
   input  logic                   rst,
   input  logic [7:0]             ps2_data,
   input  logic                   ps2_data_en,
   output logic [15:0]            rd_data,
   output logic                   rd_valid,
   input  logic                   rd_pop,
   output logic                   irq,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   bat_ok,
   output logic                   dev_err,
   input  logic                   status_clr
);
   localparam int SW = $clog2(PAUSE_SKIP + 1);

   dec_state_t  state_r, state_s;
   logic [SW-1:0] skip_r, skip_s;
   kbd_event_t  ev_s;
   logic        push_s;
   logic        set_bat_s;
   logic        set_err_s;
   logic        full_s;
   logic        overflow_r, bat_ok_r, dev_err_r;

   // Next-state decode; the event is pushed in the same cycle as its final byte.
   always_comb begin
      state_s   = state_r;
      skip_s    = skip_r;
      push_s    = 1'b0;
      ev_s      = '{rel: 1'b0, ext: 1'b0, pad: 6'd0, code: ps2_data};
      set_bat_s = 1'b0;
      set_err_s = 1'b0;
      if (ps2_data_en) begin
         if ((state_r != SKIP) && is_filtered(ps2_data)) begin
            state_s   = IDLE;
            set_bat_s = (ps2_data == PS2_BAT);
            set_err_s = is_err_byte(ps2_data);
         end else begin
            case (state_r)
               IDLE: begin
                  if (ps2_data == PS2_EXT) begin
                     state_s = EXT;
                  end else if (ps2_data == PS2_BRK) begin
                     state_s = REL;
                  end else if (ps2_data == PS2_PAUSE) begin
                     state_s = SKIP;
                     skip_s  = SW'(PAUSE_SKIP);
                  end else begin
                     push_s = 1'b1;
                  end
               end
               EXT: begin
                  if (ps2_data == PS2_BRK) begin
                     state_s = EXT_REL;
                  end else if (ps2_data == PS2_EXT) begin
                     state_s = EXT;
                  end else begin
                     push_s   = 1'b1;
                     ev_s.ext = 1'b1;
                     state_s  = IDLE;
                  end
               end
               REL: begin
                  push_s   = 1'b1;
                  ev_s.rel = 1'b1;
                  state_s  = IDLE;
               end
               EXT_REL: begin
                  push_s   = 1'b1;
                  ev_s.rel = 1'b1;
                  ev_s.ext = 1'b1;
                  state_s  = IDLE;
               end
               SKIP: begin
                  if (skip_r <= SW'(1)) begin
                     push_s    = 1'b1;
                     ev_s.ext  = 1'b1;
                     ev_s.code = PS2_PAUSE;
                     skip_s    = SW'(0);
                     state_s   = IDLE;
                  end else begin
                     skip_s = skip_r - SW'(1);
                  end
               end
               default: begin
                  state_s = IDLE;
                  skip_s  = SW'(0);
               end
            endcase
         end
      end else begin
         state_s = state_r;
      end
   end

   // Decoder state registers.
   always_ff @(posedge clk50) begin
      if (rst) begin
         state_r <= IDLE;
         skip_r  <= SW'(0);
      end else begin
         state_r <= state_s;
         skip_r  <= skip_s;
      end
   end

   // Sticky status; a set in the same cycle as status_clr wins.
   always_ff @(posedge clk50) begin
      if (rst) begin
         overflow_r <= 1'b0;
         bat_ok_r   <= 1'b0;
         dev_err_r  <= 1'b0;
      end else begin
         overflow_r <= (push_s && full_s && !rd_pop) ? 1'b1 : (status_clr ? 1'b0 : overflow_r);
         bat_ok_r   <= set_bat_s ? 1'b1 : (status_clr ? 1'b0 : bat_ok_r);
         dev_err_r  <= set_err_s ? 1'b1 : (status_clr ? 1'b0 : dev_err_r);
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk50     (clk50),
      .rst       (rst),
      .push      (push_s),
      .push_data (ev_s),
      .pop       (rd_pop),
      .head      (rd_data),
      .valid     (rd_valid),
      .full      (full_s),
      .count     (count)
   );

   assign irq      = rd_valid;
   assign overflow = overflow_r;
   assign bat_ok   = bat_ok_r;
   assign dev_err  = dev_err_r;

endmodule

// File: tb/tb_ps2_event_queue.sv
// Scoreboard bench for ps2_event_queue: expected events queued at stimulus, compared on pop.
module tb_ps2_event_queue;
   logic        clk50 = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  ps2_data = 8'h00;
   logic        ps2_data_en = 1'b0;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        rd_pop = 1'b0;
   logic        irq;
   logic [4:0]  count;
   logic        overflow;
   logic        bat_ok;
   logic        dev_err;
   logic        status_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];

   always #10 clk50 = ~clk50;

   ps2_event_queue dut (
      .clk50       (clk50),
      .rst         (rst),
      .ps2_data    (ps2_data),
      .ps2_data_en (ps2_data_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_pop      (rd_pop),
      .irq         (irq),
      .count       (count),
      .overflow    (overflow),
      .bat_ok      (bat_ok),
      .dev_err     (dev_err),
      .status_clr  (status_clr)
   );

   task automatic send(input logic [7:0] b);
      @(negedge clk50);
      ps2_data = b;
      ps2_data_en = 1'b1;
      @(negedge clk50);
      ps2_data_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk50);
      rst = 1'b1;
      repeat (2) @(negedge clk50);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic pop_one(input string name);
      logic [15:0] exp;
      @(negedge clk50);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event %h, none expected", name, rd_data);
      end else begin
         exp = sb.pop_front();
         if (rd_data !== exp) begin
            errors++;
            $display("FAIL %s: event got %h expected %h", name, rd_data, exp);
         end
      end
      rd_pop = 1'b1;
      @(negedge clk50);
      rd_pop = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (rd_valid !== 1'b1) break;
         pop_one(name);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: %0d events left got 0 expected %0d", name, sb.size(), 0);
      end
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0) begin
         errors++;
         $display("FAIL %s_empty: rd_valid=%b count=%0d expected 0/0", name, rd_valid, count);
      end
      sb.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({rd_valid, irq, count, overflow, bat_ok, dev_err, rd_data} !== 26'd0) begin
         errors++;
         $display("FAIL reset: got %h expected 0",
                  {rd_valid, irq, count, overflow, bat_ok, dev_err, rd_data});
      end
   endtask

   task automatic test_make();
      sb.push_back(16'h001C);
      send(8'h1C);
      checks++;
      if (rd_valid !== 1'b1 || irq !== 1'b1 || rd_data !== 16'h001C) begin
         errors++;
         $display("FAIL make_latency: valid=%b irq=%b data=%h expected 1 1 001c", rd_valid, irq, rd_data);
      end
      drain("make");
   endtask

   task automatic test_prefixes();
      sb.push_back(16'hC075);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hFA);
      sb.push_back(16'h801C);
      send(8'hF0); send(8'h1C);
      checks++;
      if (count !== 5'd2) begin
         errors++;
         $display("FAIL prefix_count: got %0d expected 2", count);
      end
      drain("prefix");
   endtask

   task automatic test_pause();
      logic [7:0] seq [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      send(8'hE1);
      for (int i = 0; i < 7; i++) begin
         if (i == 6) sb.push_back(16'h40E1);
         send(seq[i]);
         if (i == 5) begin
            checks++;
            if (count !== 5'd0) begin
               errors++;
               $display("FAIL pause_early: count got %0d expected 0", count);
            end
         end
      end
      checks++;
      if (count !== 5'd1) begin
         errors++;
         $display("FAIL pause_count: got %0d expected 1", count);
      end
      sb.push_back(16'h0029);
      send(8'h29);
      drain("pause");
   endtask

   task automatic test_overflow();
      logic [15:0] exp;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) sb.push_back(16'h0010 + 16'(i));
         send(8'h10 + 8'(i));
      end
      checks++;
      if (count !== 5'd16 || overflow !== 1'b1 || rd_data !== 16'h0010) begin
         errors++;
         $display("FAIL ovf_full: count=%0d ovf=%b head=%h expected 16 1 0010", count, overflow, rd_data);
      end
      @(negedge clk50);
      exp = sb.pop_front();
      checks++;
      if (rd_data !== exp) begin
         errors++;
         $display("FAIL ovf_head: got %h expected %h", rd_data, exp);
      end
      sb.push_back(16'h0040);
      rd_pop = 1'b1; ps2_data = 8'h40; ps2_data_en = 1'b1;
      @(negedge clk50);
      rd_pop = 1'b0; ps2_data_en = 1'b0;
      checks++;
      if (count !== 5'd16 || overflow !== 1'b1 || rd_data !== 16'h0011) begin
         errors++;
         $display("FAIL ovf_pushpop: count=%0d ovf=%b head=%h expected 16 1 0011", count, overflow, rd_data);
      end
      status_clr = 1'b1;
      @(negedge clk50);
      status_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b expected 0", overflow);
      end
      drain("overflow");
   endtask

   task automatic test_status();
      send(8'hAA);
      checks++;
      if (bat_ok !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL bat: bat_ok=%b count=%0d expected 1 0", bat_ok, count);
      end
      send(8'hE0); send(8'hFC);
      checks++;
      if (dev_err !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL dev_err: dev_err=%b count=%0d expected 1 0", dev_err, count);
      end
      sb.push_back(16'h001C);
      send(8'h1C);
      drain("abort");
      @(negedge clk50);
      status_clr = 1'b1; ps2_data = 8'hAA; ps2_data_en = 1'b1;
      @(negedge clk50);
      status_clr = 1'b0; ps2_data_en = 1'b0;
      checks++;
      if (bat_ok !== 1'b1 || dev_err !== 1'b0) begin
         errors++;
         $display("FAIL set_wins: bat_ok=%b dev_err=%b expected 1 0", bat_ok, dev_err);
      end
   endtask

   task automatic test_reset_mid();
      send(8'hE0);
      do_reset();
      checks++;
      if ({rd_valid, count, overflow, bat_ok, dev_err} !== 9'd0) begin
         errors++;
         $display("FAIL reset_mid: got %h expected 0", {rd_valid, count, overflow, bat_ok, dev_err});
      end
      sb.push_back(16'h0075);
      send(8'h75);
      drain("reset_mid");
   endtask

   task automatic test_back_to_back();
      sb.push_back(16'h4074);
      sb.push_back(16'h001C);
      @(negedge clk50);
      ps2_data = 8'hE0; ps2_data_en = 1'b1;
      @(negedge clk50);
      ps2_data = 8'h74;
      @(negedge clk50);
      ps2_data = 8'h1C;
      @(negedge clk50);
      ps2_data_en = 1'b0;
      checks++;
      if (count !== 5'd2) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 2", count);
      end
      drain("b2b");
      sb.push_back(16'h002B);
      @(negedge clk50);
      rd_pop = 1'b1; ps2_data = 8'h2B; ps2_data_en = 1'b1;
      @(negedge clk50);
      rd_pop = 1'b0; ps2_data_en = 1'b0;
      checks++;
      if (count !== 5'd1) begin
         errors++;
         $display("FAIL empty_pushpop: count got %0d expected 1", count);
      end
      drain("empty_pushpop");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_make();
      test_prefixes();
      test_pause();
      test_overflow();
      test_status();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
